// File: rtl/alpha_blend_stage_if.sv
// Pixel stream bundle for alpha_blend_stage: source-side beat in, blended beat out.
// slave = the blend stage, master = whatever drives the source and sinks the output.
interface alpha_blend_stage_if #(
   parameter int CH_W = 8
);
   logic [3*CH_W-1:0] in_pixel;
   logic              in_sof;
   logic              in_eol;
   logic              in_valid;
   logic              in_ready;
   logic [3*CH_W-1:0] out_pixel;
   logic              out_sof;
   logic              out_eol;
   logic              out_valid;
   logic              out_ready;

   modport slave (
      input  in_pixel, in_sof, in_eol, in_valid,
      output in_ready,
      output out_pixel, out_sof, out_eol, out_valid,
      input  out_ready
   );

   modport master (
      output in_pixel, in_sof, in_eol, in_valid,
      input  in_ready,
      input  out_pixel, out_sof, out_eol, out_valid,
      output out_ready
   );
endinterface

// File: rtl/alpha_blend_stage.sv
// Two-stage valid/ready alpha blend of a flat overlay colour onto an RGB stream.
// Optional macro ALPHA_ROUND_EN: round-half-up instead of truncating the final /4.
module alpha_blend_stage #(
   parameter int CH_W   = 8,
   parameter int FCNT_W = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [2:0]           color,
   input  logic [2:0]           alpha_q,
   alpha_blend_stage_if.slave   bus,
   output logic [FCNT_W-1:0]    frame_count
);

   localparam int PX_W  = 3 * CH_W;
   localparam int SUM_W = CH_W + 3;

   function automatic logic [2:0] clamp_alpha(input logic [2:0] a);
      return (a > 3'd4) ? 3'd4 : a;
   endfunction

   function automatic logic [CH_W-1:0] scale_sum(input logic [SUM_W-1:0] s);
      logic [SUM_W-1:0] r;
`ifdef ALPHA_ROUND_EN
      r = s + SUM_W'(2);
`else
      r = s;
`endif
      r = r >> 2;
      return r[CH_W-1:0];
   endfunction

   logic              accept;
   logic              s2_free;
   logic [2:0]        act_color_q, act_color_d;
   logic [2:0]        act_alpha_q, act_alpha_d;
   logic [2:0]        sel_color;
   logic [2:0]        sel_alpha;

   logic [SUM_W-1:0]  ovp_d    [3];
   logic [SUM_W-1:0]  pxp_d    [3];
   logic [SUM_W-1:0]  ovp_p1_q [3];
   logic [SUM_W-1:0]  pxp_p1_q [3];
   logic              sof_p1_q, eol_p1_q, vld_p1_q;

   logic [PX_W-1:0]   pix_d;
   logic [PX_W-1:0]   pix_p2_q;
   logic              sof_p2_q, eol_p2_q, vld_p2_q;
   logic [FCNT_W-1:0] fc_q, fc_d;

   assign s2_free     = !vld_p2_q || bus.out_ready;
   assign bus.in_ready = !vld_p1_q || s2_free;
   assign accept      = bus.in_valid && bus.in_ready;

   // A sof beat blends with the settings it carries, not the stale held ones.
   always_comb begin
      sel_color   = act_color_q;
      sel_alpha   = act_alpha_q;
      act_color_d = act_color_q;
      act_alpha_d = act_alpha_q;
      if (bus.in_sof) begin
         sel_color = color;
         sel_alpha = clamp_alpha(alpha_q);
      end
      if (accept && bus.in_sof) begin
         act_color_d = sel_color;
         act_alpha_d = sel_alpha;
      end
   end

   always_comb begin
      for (int c = 0; c < 3; c++) begin
         ovp_d[c] = SUM_W'(sel_color[c] ? {CH_W{1'b1}} : {CH_W{1'b0}}) * SUM_W'(sel_alpha);
         pxp_d[c] = SUM_W'(bus.in_pixel[c*CH_W +: CH_W]) * SUM_W'(3'd4 - sel_alpha);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         act_color_q <= 3'd0;
         act_alpha_q <= 3'd4;
      end else begin
         act_color_q <= act_color_d;
         act_alpha_q <= act_alpha_d;
      end
   end

   // ---- stage 1: per-channel products ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1_q <= 1'b0;
      end else if (bus.in_ready) begin
         vld_p1_q <= bus.in_valid;
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         for (int c = 0; c < 3; c++) begin
            ovp_p1_q[c] <= ovp_d[c];
            pxp_p1_q[c] <= pxp_d[c];
         end
         sof_p1_q <= bus.in_sof;
         eol_p1_q <= bus.in_eol;
      end
   end

   // ---- stage 2: sum, divide by four, sideband ----
   always_comb begin
      pix_d = '0;
      for (int c = 0; c < 3; c++) begin
         pix_d[c*CH_W +: CH_W] = scale_sum(ovp_p1_q[c] + pxp_p1_q[c]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p2_q <= 1'b0;
         pix_p2_q <= '0;
         sof_p2_q <= 1'b0;
         eol_p2_q <= 1'b0;
      end else if (s2_free) begin
         vld_p2_q <= vld_p1_q;
         if (vld_p1_q) begin
            pix_p2_q <= pix_d;
            sof_p2_q <= sof_p1_q;
            eol_p2_q <= eol_p1_q;
         end
      end
   end

   assign fc_d = (vld_p2_q && bus.out_ready && sof_p2_q) ? fc_q + FCNT_W'(1) : fc_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fc_q <= '0;
      end else begin
         fc_q <= fc_d;
      end
   end

   assign bus.out_pixel = pix_p2_q;
   assign bus.out_sof   = sof_p2_q;
   assign bus.out_eol   = eol_p2_q;
   assign bus.out_valid = vld_p2_q;
   assign frame_count   = fc_q;

endmodule
